// File: rtl/serial_add_pkg.sv
// ============================================================================
// serial_add_pkg : shared state encoding and counter sizing for serial_add
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_add.sv
// ============================================================================
// full_add : one-bit full adder cell
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module full_add (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (a & c) | (b & c);

endmodule

`default_nettype wire

// File: rtl/serial_add.sv
// ============================================================================
// serial_add : bit-serial adder, LSB first, valid/ready on both sides
// Optional ovf output enabled by defining SERIAL_ADD_OVF_EN
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module serial_add
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             CW     = cnt_w(WIDTH);
  localparam logic [CW-1:0]  c_last = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_c;

  full_add u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .c    (r_carry),
    .sum  (w_s),
    .cout (w_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            r_a      <= a;
            r_b      <= b;
            r_carry  <= cin;
            r_cnt    <= '0;
            r_state  <= ST_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          // Sum bits enter at the MSB so bit 0 lands in place after WIDTH shifts
          sum     <= {w_s, sum[WIDTH-1:1]};
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_c;
          if (r_cnt == c_last) begin
            r_state   <= ST_DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            cout      <= w_c;
`ifdef SERIAL_ADD_OVF_EN
            ovf       <= r_carry ^ w_c;
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state   <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/serial_add.md
SERIAL_ADD -- requirements
Module: serial_add

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand and sum width in bits; legal range 2..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operands a, b and cin are valid.
REQ-005 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have ports a and b  input  WIDTH  addend operands, unsigned or two's complement.
REQ-007 SHALL have port cin  input  1  carry-in.
REQ-008 SHALL have port out_valid  output  1  sum, cout (and ovf) are valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port sum  output  WIDTH  result a+b+cin modulo 2^WIDTH.
REQ-011 SHALL have port cout  output  1  carry out of the MSB.
REQ-012 SHALL have port busy  output  1  high while the bit-serial addition is in progress.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE.
REQ-014 SHALL drive in_ready high only in IDLE, busy high only in RUN, and out_valid high only in DONE.
REQ-015 SHALL, on in_valid&&in_ready in IDLE, load a, b and cin into shift and carry registers, clear the bit counter and enter RUN.
REQ-016 SHALL, each RUN cycle, add one bit per cycle, LSB first: a_sh[0], b_sh[0], carry; shift the sum bit into the sum register MSB, shift a_sh and b_sh right, update carry and increment the counter.
REQ-017 SHALL enter DONE after processing bit WIDTH-1, so out_valid rises exactly WIDTH rising edges after the accepting edge.
REQ-018 SHALL hold sum, cout, ovf and out_valid stable in DONE until out_valid&&out_ready.
REQ-019 SHALL return to IDLE on that out_valid&&out_ready handshake, without accepting new operands in the same cycle; sum and cout keep their last values in IDLE.
REQ-020 SHALL ignore in_valid and operand changes while in RUN or DONE; the counter never wraps past WIDTH-1.
REQ-021 SHALL compute cout as the carry after bit WIDTH-1, including the case all-ones+all-ones+cin=1, which gives sum all-ones and cout=1.

Reset
REQ-022 SHALL, while rst_n is low, force state IDLE, counter 0, and sum, cout, ovf, out_valid and busy to 0, with in_ready=1 once reset releases.
REQ-023 SHALL, when reset asserts mid-RUN or mid-DONE, discard the operation with no partial result emitted.

Configuration
REQ-024 SHALL, with macro SERIAL_ADD_OVF_EN defined, add port ovf  output  1, equal to the carry into bit WIDTH-1 XOR cout, captured on the last RUN cycle and valid with out_valid.
REQ-025 SHALL, without SERIAL_ADD_OVF_EN, omit the ovf port and its logic; all other behaviour is identical.

Structure
REQ-026 SHALL take the state enum typedef and the counter-width function, $clog2(WIDTH), from shared package serial_add_pkg.
REQ-027 SHALL instantiate the existing one-bit cell full_add (ports a, b, c, sum, cout) as its single sub-module for the per-bit add.

Verification
REQ-028 SHALL cover, with WIDTH=8: 0x00+0x00, cin=0 -> out_valid 8 edges after accept, sum=0x00, cout=0.
REQ-029 SHALL cover, with WIDTH=8: 0xFF+0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
REQ-030 SHALL cover, with WIDTH=8: 0x7F+0x01, cin=0 -> sum=0x80, cout=0, ovf=1; and 0xFF+0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-031 SHALL cover back-pressure: out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored; release -> IDLE next cycle.
REQ-032 SHALL cover reset mid-operation: rst_n low on the 3rd RUN cycle -> all outputs 0 immediately, IDLE; the next operation 0x12+0x34 gives sum=0x46.
REQ-033 SHALL cover, with WIDTH=2: all 32 combinations of a, b and cin -> {cout,sum} == a+b+cin for each.
